// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 op codes,
// FSM state encoding and the constants returned by the divide special cases.
package mdu_pkg;

    localparam int MDU_XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [MDU_XLEN-1:0] QUO_ALL_ONES = '1;
    localparam logic [MDU_XLEN-1:0] MOST_NEG     = {1'b1, {(MDU_XLEN-1){1'b0}}};

endpackage

// File: rtl/mdu_div_core.sv
// One restoring-divide step per cycle on unsigned magnitudes: the dividend
// shifts out of the top of quo while quotient bits shift in at the bottom.
module mdu_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem
);

    logic [XLEN-1:0] dvsr;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;

    assign rem_sh = {rem, quo[XLEN-1]};
    assign diff   = rem_sh - {1'b0, dvsr};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quo  <= '0;
            rem  <= '0;
            dvsr <= '0;
        end else if (load) begin
            quo  <= dividend;
            rem  <= '0;
            dvsr <= divisor;
        end else if (step) begin
            // a clear borrow bit means the trial subtraction fits
            if (!diff[XLEN]) begin
                rem <= diff[XLEN-1:0];
                quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
                rem <= rem_sh[XLEN-1:0];
                quo <= {quo[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: XLEN radix-2 steps on magnitudes, then sign fix-up.
// Define MDU_DIV_EN to build the divider; without it ops 4-7 return 0 via the fast path.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    state_t            state;
    logic [5:0]        cnt;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic              neg_q;
    logic              spec_q;
    logic              fix_ph;
    logic [XLEN-1:0]   mag_a;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   fix_val;

    logic              accept;
    logic              a_signed, b_signed, sa, sb;
    logic              neg_in, spec_in;
    logic [XLEN-1:0]   mag_a_in, mag_b_in, spec_val_in;
    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   fixed_slice;

    assign accept   = start && (state == S_IDLE || state == S_DONE);
    assign a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign sa       = a_signed && rs1_val[XLEN-1];
    assign sb       = b_signed && rs2_val[XLEN-1];
    assign mag_a_in = sa ? -rs1_val : rs1_val;
    assign mag_b_in = sb ? -rs2_val : rs2_val;
    // remainders follow the dividend's sign, everything else the sign product
    assign neg_in   = (op[2] && op[1]) ? sa : (sa ^ sb);

`ifdef MDU_DIV_EN
    logic            div_zero, div_ovf, is_rem_in;
    logic [XLEN-1:0] quo, rem, div_val;

    assign is_rem_in = op[1];
    assign div_zero  = (rs2_val == '0);
    assign div_ovf   = ((op == OP_DIV) || (op == OP_REM)) &&
                       (rs1_val == MOST_NEG) && (rs2_val == QUO_ALL_ONES);
    assign spec_in   = op[2] && (div_zero || div_ovf);
    assign spec_val_in = div_zero ? (is_rem_in ? rs1_val : QUO_ALL_ONES)
                                  : (is_rem_in ? '0 : MOST_NEG);
    assign div_val   = op_q[1] ? rem : quo;

    mdu_div_core #(.XLEN(XLEN)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .step     (state == S_CALC),
        .dividend (mag_a_in),
        .divisor  (mag_b_in),
        .quo      (quo),
        .rem      (rem)
    );
`else
    assign spec_in     = op[2];
    assign spec_val_in = '0;
`endif

    assign sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mag_a : {XLEN{1'b0}})};
    assign prod_s = neg_q ? -acc : acc;

    always_comb begin
        fixed_slice = '0;
        if (op_q[2]) begin
`ifdef MDU_DIV_EN
            fixed_slice = neg_q ? -div_val : div_val;
`endif
        end else if (op_q == OP_MUL) begin
            fixed_slice = prod_s[XLEN-1:0];
        end else begin
            fixed_slice = prod_s[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            neg_q   <= 1'b0;
            spec_q  <= 1'b0;
            fix_ph  <= 1'b0;
            mag_a   <= '0;
            acc     <= '0;
            fix_val <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            rd_out  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    state <= S_IDLE;
                    if (accept) begin
                        op_q    <= op;
                        rd_q    <= rd_in;
                        neg_q   <= spec_in ? 1'b0 : neg_in;
                        spec_q  <= spec_in;
                        fix_val <= spec_val_in;
                        fix_ph  <= 1'b0;
                        mag_a   <= mag_a_in;
                        acc     <= {{XLEN{1'b0}}, mag_b_in};
                        cnt     <= 6'(XLEN-1);
                        busy    <= 1'b1;
                        state   <= spec_in ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    acc <= {sum, acc[XLEN-1:1]};
                    if (cnt == '0) begin
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                S_FIX: begin
                    // first cycle selects and signs the slice, second publishes it
                    if (!fix_ph) begin
                        fix_ph <= 1'b1;
                        if (!spec_q) begin
                            fix_val <= fixed_slice;
                        end
                    end else begin
                        fix_ph <= 1'b0;
                        result <= fix_val;
                        rd_out <= rd_q;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
